// File: rtl/multi_lane_eye_scan.sv
// Multi-lane IDELAY eye scanner: sweeps each masked lane's N-side tap, counts P/N word
// mismatches per scan point, then loads the centre of the widest clean run into P and N.
module multi_lane_eye_scan #(
  parameter int N_LANES    = 4,
  parameter int TAP_W      = 9,
  parameter int MAX_TAP    = 511,
  parameter int TAP_STEP   = 8,
  parameter int WINDOW     = 256,
  parameter int SETTLE     = 16,
  parameter int ERR_THRESH = 0,
  parameter int TIMEOUT    = 1024,
  parameter int DELAY_INIT = 0
) (
  input  logic                       i_clk160,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [N_LANES-1:0]         i_lane_mask,
  input  logic [8*N_LANES-1:0]       i_data_P,
  input  logic [8*N_LANES-1:0]       i_data_N,
  input  logic [N_LANES-1:0]         i_data_valid,
  output logic [TAP_W-1:0]           o_delay_value,
  output logic [N_LANES-1:0]         o_delay_load_P,
  output logic [N_LANES-1:0]         o_delay_load_N,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [TAP_W*N_LANES-1:0]   o_lane_tap,
  output logic [TAP_W*N_LANES-1:0]   o_lane_width,
  output logic [N_LANES-1:0]         o_lane_fail
);

  localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int ERR_W  = $clog2(8*WINDOW+1);
  localparam int WORD_W = $clog2(WINDOW+1);
  localparam int CNT_W  = $clog2(TIMEOUT+SETTLE+1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_MEASURE, S_EVAL, S_CENTRE, S_APPLY, S_NEXT, S_DONE
  } state_t;

  state_t              r_state, w_stateNext;
  logic [N_LANES-1:0]  r_mask;
  logic [LANE_W-1:0]   r_lane;
  logic [TAP_W-1:0]    r_tap;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_words;
  logic [ERR_W-1:0]    r_err;
  logic                r_timeout;
  logic [TAP_W-1:0]    r_curLen, r_curStart, r_bestLen, r_bestStart;
  logic [TAP_W-1:0]    r_centre, r_delayHold;
  logic                r_busy, r_done;
  logic [TAP_W-1:0]    r_laneTap   [N_LANES];
  logic [TAP_W-1:0]    r_laneWidth [N_LANES];
  logic [N_LANES-1:0]  r_laneFail;

  logic [LANE_W-1:0]   w_firstLane, w_nextLane;
  logic                w_firstValid, w_nextValid;
  logic [N_LANES-1:0]  w_laneHot;
  logic [7:0]          w_laneP, w_laneN;
  logic                w_laneValid;
  logic [WORD_W-1:0]   w_wordsNext;
  logic [ERR_W-1:0]    w_errNext;
  logic                w_measComplete, w_measTimeout, w_settleDone;
  logic [TAP_W:0]      w_tapSum;
  logic                w_tapEnd, w_clean;
  logic [TAP_W-1:0]    w_curLenNew, w_curStartNew, w_centre;

  // Descending loops so the lowest qualifying lane index wins.
  always_comb begin
    w_firstLane  = '0;
    w_firstValid = 1'b0;
    w_nextLane   = '0;
    w_nextValid  = 1'b0;
    for (int i = N_LANES-1; i >= 0; i--) begin
      if (i_lane_mask[i]) begin
        w_firstLane  = LANE_W'(i);
        w_firstValid = 1'b1;
      end
      if (r_mask[i] && (i > int'(r_lane))) begin
        w_nextLane  = LANE_W'(i);
        w_nextValid = 1'b1;
      end
    end
  end

  assign w_laneHot      = N_LANES'(1) << r_lane;
  assign w_laneP        = i_data_P[8*r_lane +: 8];
  assign w_laneN        = i_data_N[8*r_lane +: 8];
  assign w_laneValid    = i_data_valid[r_lane];
  assign w_wordsNext    = r_words + WORD_W'(w_laneValid);
  assign w_errNext      = r_err + (w_laneValid ? ERR_W'($countones(w_laneP ^ ~w_laneN)) : '0);
  assign w_measComplete = (w_wordsNext == WORD_W'(WINDOW));
  assign w_measTimeout  = (r_cnt == CNT_W'(TIMEOUT-1));
  assign w_settleDone   = (r_cnt == CNT_W'(SETTLE-1));
  assign w_tapSum       = {1'b0, r_tap} + (TAP_W+1)'(TAP_STEP);
  assign w_tapEnd       = (w_tapSum > (TAP_W+1)'(MAX_TAP));
  assign w_clean        = (r_err <= ERR_W'(ERR_THRESH)) && !r_timeout;
  assign w_curLenNew    = w_clean ? (r_curLen + 1'b1) : '0;
  assign w_curStartNew  = (w_clean && (r_curLen == '0)) ? r_tap : r_curStart;
  assign w_centre       = (r_bestLen == '0) ? TAP_W'(DELAY_INIT) :
                          r_bestStart + TAP_W'(((32'(r_bestLen) - 32'd1) * 32'(TAP_STEP)) >> 1);

  always_ff @(posedge i_clk160) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_stateNext = w_firstValid ? S_LOAD : S_DONE;
      S_LOAD:    w_stateNext = S_SETTLE;
      S_SETTLE:  if (w_settleDone) w_stateNext = S_MEASURE;
      S_MEASURE: if (w_measComplete || w_measTimeout) w_stateNext = S_EVAL;
      S_EVAL:    w_stateNext = w_tapEnd ? S_CENTRE : S_LOAD;
      S_CENTRE:  w_stateNext = S_APPLY;
      S_APPLY:   w_stateNext = S_NEXT;
      S_NEXT:    w_stateNext = w_nextValid ? S_LOAD : S_DONE;
      S_DONE:    w_stateNext = S_IDLE;
      default:   w_stateNext = S_IDLE;
    endcase
    if (i_abort) w_stateNext = S_IDLE;
  end

  // Strobes decode straight from state so each lasts exactly one clock; the bus value is held afterwards.
  assign o_delay_load_N = ((r_state == S_LOAD) || (r_state == S_APPLY)) ? w_laneHot : '0;
  assign o_delay_load_P = (r_state == S_APPLY) ? w_laneHot : '0;
  assign o_delay_value  = (r_state == S_LOAD)  ? r_tap :
                          (r_state == S_APPLY) ? r_centre : r_delayHold;

  always_ff @(posedge i_clk160) begin
    if (i_rst) begin
      r_mask <= '0; r_lane <= '0; r_tap <= '0; r_cnt <= '0;
      r_words <= '0; r_err <= '0; r_timeout <= 1'b0;
      r_curLen <= '0; r_curStart <= '0; r_bestLen <= '0; r_bestStart <= '0;
      r_centre <= '0; r_delayHold <= '0; r_busy <= 1'b0; r_done <= 1'b0;
      r_laneFail <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        r_laneTap[i]   <= TAP_W'(DELAY_INIT);
        r_laneWidth[i] <= '0;
      end
    end else begin
      r_delayHold <= o_delay_value;
      r_done      <= 1'b0;
      if (i_abort) begin
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (i_start) begin
            r_mask <= i_lane_mask;
            r_lane <= w_firstLane;
            r_tap  <= '0;
            r_busy <= 1'b1;
          end
          S_LOAD: begin
            r_cnt <= '0; r_words <= '0; r_err <= '0; r_timeout <= 1'b0;
            if (r_tap == '0) begin
              r_curLen <= '0; r_curStart <= '0; r_bestLen <= '0; r_bestStart <= '0;
            end
          end
          S_SETTLE: r_cnt <= w_settleDone ? '0 : (r_cnt + 1'b1);
          S_MEASURE: begin
            r_words <= w_wordsNext;
            r_err   <= w_errNext;
            r_cnt   <= r_cnt + 1'b1;
            if (w_measTimeout && !w_measComplete) r_timeout <= 1'b1;
          end
          S_EVAL: begin
            r_curLen   <= w_curLenNew;
            r_curStart <= w_curStartNew;
            if (w_clean && (w_curLenNew > r_bestLen)) begin
              r_bestLen   <= w_curLenNew;
              r_bestStart <= w_curStartNew;
            end
            r_tap <= w_tapSum[TAP_W-1:0];
          end
          S_CENTRE: begin
            r_centre               <= w_centre;
            r_laneTap[r_lane]      <= w_centre;
            r_laneWidth[r_lane]    <= r_bestLen;
            r_laneFail[r_lane]     <= (r_bestLen == '0);
          end
          S_NEXT: begin
            r_lane <= w_nextLane;
            r_tap  <= '0;
          end
          S_DONE: begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_lane_fail = r_laneFail;

  for (genvar g = 0; g < N_LANES; g++) begin : g_pack
    assign o_lane_tap[g*TAP_W +: TAP_W]   = r_laneTap[g];
    assign o_lane_width[g*TAP_W +: TAP_W] = r_laneWidth[g];
  end

endmodule

// File: tb/tb_multi_lane_eye_scan.sv
// Directed bench for multi_lane_eye_scan: a per-lane IDELAY model injects errors at chosen taps
// and the scan results, strobes and handshakes are compared against hand-computed values.
module tb_multi_lane_eye_scan;

  localparam int N_LANES = 4;
  localparam int TAP_W   = 9;

  logic                      clk = 1'b0;
  logic                      rst, start, abort;
  logic [N_LANES-1:0]        laneMask, dataValid;
  logic [8*N_LANES-1:0]      dataP, dataN;
  logic [TAP_W-1:0]          delayValue;
  logic [N_LANES-1:0]        loadP, loadN, laneFail;
  logic                      busy, done;
  logic [TAP_W*N_LANES-1:0]  laneTap, laneWidth;

  int testsRun  = 0;
  int failCount = 0;
  int curTap [N_LANES];
  int pattern [N_LANES];
  logic [N_LANES-1:0] validEn;
  int loadPCount = 0, loadNCount = 0, doneCount = 0, multiCount = 0;
  int applyValue = 0;
  int snapP, snapN, snapDone;

  always #5 clk = ~clk;

  multi_lane_eye_scan #(.WINDOW(8), .SETTLE(4), .TIMEOUT(32)) dut (
    .i_clk160(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_lane_mask(laneMask), .i_data_P(dataP), .i_data_N(dataN), .i_data_valid(dataValid),
    .o_delay_value(delayValue), .o_delay_load_P(loadP), .o_delay_load_N(loadN),
    .o_busy(busy), .o_done(done), .o_lane_tap(laneTap), .o_lane_width(laneWidth),
    .o_lane_fail(laneFail)
  );

  // 0 = always clean, 1 = clean 64..199, 2 = always errors, 3 = clean 40..80 and 296..336
  function automatic bit isBad(int pat, int tap);
    case (pat)
      0: return 1'b0;
      1: return (tap < 64) || (tap >= 200);
      2: return 1'b1;
      default: return !(((tap >= 40) && (tap <= 80)) || ((tap >= 296) && (tap <= 336)));
    endcase
  endfunction

  // Models the N-side IDELAY of each lane and tallies every strobe and done pulse.
  always @(posedge clk) begin
    for (int i = 0; i < N_LANES; i++)
      if (loadN[i]) curTap[i] <= int'(delayValue);
    loadPCount <= loadPCount + int'(|loadP);
    loadNCount <= loadNCount + $countones(loadN);
    doneCount  <= doneCount + int'(done);
    if (($countones(loadP) > 1) || ($countones(loadN) > 1)) multiCount <= multiCount + 1;
    if (|loadP) applyValue <= int'(delayValue);
  end

  // N word is the true complement of P unless the lane's current tap sits in an error region.
  always @(negedge clk) begin
    logic [8*N_LANES-1:0] pv, nv;
    pv = $urandom;
    for (int i = 0; i < N_LANES; i++)
      nv[8*i +: 8] = isBad(pattern[i], curTap[i]) ? pv[8*i +: 8] : ~pv[8*i +: 8];
    dataP     <= pv;
    dataN     <= nv;
    dataValid <= validEn;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N_LANES-1:0] mask, input logic withAbort);
    @(negedge clk);
    start    = 1'b1;
    abort    = withAbort;
    laneMask = mask;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles);
    int n = 0;
    while (!done && (n < maxCycles)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", done, 1);
    @(negedge clk);
  endtask

  function automatic logic [TAP_W-1:0] tapOf(int l);
    return laneTap[l*TAP_W +: TAP_W];
  endfunction

  function automatic logic [TAP_W-1:0] widthOf(int l);
    return laneWidth[l*TAP_W +: TAP_W];
  endfunction

  task automatic snapshot();
    snapP = loadPCount; snapN = loadNCount; snapDone = doneCount;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; laneMask = '0; validEn = '1;
    for (int i = 0; i < N_LANES; i++) begin curTap[i] = 0; pattern[i] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstDelay", delayValue, 0);
    checkOutput("rstLoads", {loadP, loadN}, 0);
    checkOutput("rstTap", laneTap, 0);
    checkOutput("rstWidth", laneWidth, 0);
    checkOutput("rstFail", laneFail, 0);

    // Single lane, clean window 64..192 in step-8 points
    pattern[0] = 1;
    snapshot();
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t1Busy", busy, 1);
    waitDone(3000);
    checkOutput("t1Tap", tapOf(0), 128);
    checkOutput("t1Width", widthOf(0), 17);
    checkOutput("t1Fail", laneFail, 4'b0000);
    checkOutput("t1ApplyCount", loadPCount - snapP, 1);
    checkOutput("t1LoadNCount", loadNCount - snapN, 65);
    checkOutput("t1ApplyValue", applyValue, 128);
    checkOutput("t1DoneCount", doneCount - snapDone, 1);
    checkOutput("t1BusyEnd", busy, 0);

    // Lane 1 never clean
    pattern[1] = 2;
    snapshot();
    applyStimulus(4'b0011, 1'b0);
    waitDone(5000);
    checkOutput("t2Tap1", tapOf(1), 0);
    checkOutput("t2Width1", widthOf(1), 0);
    checkOutput("t2Fail", laneFail, 4'b0010);
    checkOutput("t2Tap0", tapOf(0), 128);
    checkOutput("t2DoneCount", doneCount - snapDone, 1);

    // Lane 2 starved of valid words: every point times out
    validEn = 4'b1011;
    applyStimulus(4'b0100, 1'b0);
    waitDone(6000);
    validEn = 4'b1111;
    checkOutput("t3Fail", laneFail, 4'b0110);
    checkOutput("t3Tap2", tapOf(2), 0);
    checkOutput("t3Width2", widthOf(2), 0);

    // Two six-point clean runs: the earlier one must win
    pattern[3] = 3;
    applyStimulus(4'b1000, 1'b0);
    waitDone(3000);
    checkOutput("t4Tap3", tapOf(3), 60);
    checkOutput("t4Width3", widthOf(3), 6);
    checkOutput("t4Fail", laneFail, 4'b0110);

    // Abort while measuring lane 1; lane 1 would otherwise turn fully clean
    pattern[1] = 0;
    snapshot();
    applyStimulus(4'b0011, 1'b0);
    begin
      int n = 0;
      while (!loadN[1] && (n < 3000)) begin
        @(negedge clk);
        n++;
      end
      checkOutput("t5Lane1Load", loadN[1], 1);
    end
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t5BusyAbort", busy, 0);
    snapN = loadNCount;
    repeat (40) @(negedge clk);
    checkOutput("t5NoDone", doneCount - snapDone, 0);
    checkOutput("t5Idle", loadNCount - snapN, 0);
    checkOutput("t5Tap0", tapOf(0), 128);
    checkOutput("t5Width0", widthOf(0), 17);
    checkOutput("t5Tap1", tapOf(1), 0);
    checkOutput("t5Width1", widthOf(1), 0);
    checkOutput("t5Fail", laneFail, 4'b0110);

    // Start and abort in the same clock: scan must not begin
    applyStimulus(4'b0001, 1'b1);
    checkOutput("abortWins", busy, 0);

    // Reset mid-scan, then an empty-mask start
    applyStimulus(4'b0001, 1'b0);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6RstBusy", busy, 0);
    checkOutput("t6RstTap", laneTap, 0);
    checkOutput("t6RstWidth", laneWidth, 0);
    checkOutput("t6RstFail", laneFail, 0);
    checkOutput("t6RstDelay", delayValue, 0);
    rst = 1'b0;
    snapshot();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("t6Busy", busy, 1);
    checkOutput("t6DoneEarly", done, 0);
    @(negedge clk);
    checkOutput("t6Done", done, 1);
    checkOutput("t6BusyLow", busy, 0);
    @(negedge clk);
    checkOutput("t6DonePulse", done, 0);
    checkOutput("t6NoLoads", (loadPCount - snapP) + (loadNCount - snapN), 0);
    checkOutput("oneHotStrobes", multiCount, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
